// File: rtl/data_memory_controller_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_memory_controller_pkg                                            |
// | Shared memory-op encodings, FSM state type and op decode helpers.     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package data_memory_controller_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'b0000,
      OP_SB   = 4'b0101,
      OP_SH   = 4'b0110,
      OP_SW   = 4'b0111,
      OP_LB   = 4'b1000,
      OP_LH   = 4'b1001,
      OP_LW   = 4'b1010,
      OP_LBU  = 4'b1100,
      OP_LHU  = 4'b1101
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_e;

   typedef struct packed {
      logic         valid;
      logic         is_load;
      logic         is_signed;
      access_size_e size;
   } op_decode_t;

   // Any code outside the table decodes as NONE (valid = 0).
   function automatic op_decode_t decode_op(input logic [3:0] op);
      op_decode_t d;
      d.valid     = 1'b1;
      d.is_load   = 1'b0;
      d.is_signed = 1'b0;
      d.size      = SZ_WORD;
      case (op)
         OP_LB:  begin d.is_load = 1'b1; d.is_signed = 1'b1; d.size = SZ_BYTE; end
         OP_LH:  begin d.is_load = 1'b1; d.is_signed = 1'b1; d.size = SZ_HALF; end
         OP_LW:  begin d.is_load = 1'b1; d.size = SZ_WORD; end
         OP_LBU: begin d.is_load = 1'b1; d.size = SZ_BYTE; end
         OP_LHU: begin d.is_load = 1'b1; d.size = SZ_HALF; end
         OP_SB:  d.size = SZ_BYTE;
         OP_SH:  d.size = SZ_HALF;
         OP_SW:  d.size = SZ_WORD;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
      logic m;
      case (size)
         SZ_HALF: m = addr_lo[0];
         SZ_WORD: m = |addr_lo;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_lane_align                                                   |
// | Combinational store lane/mask generation and load extension.          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module data_mem_lane_align
   import data_memory_controller_pkg::*;
(
   input  logic         i_size_byte_unused_guard,
   input  access_size_e i_size,
   input  logic         i_is_signed,
   input  logic [1:0]   i_addr_lo,
   input  logic [31:0]  i_store_data,
   input  logic [31:0]  i_mem_word,
   output logic [3:0]   o_byte_mask,
   output logic [31:0]  o_store_word,
   output logic [31:0]  o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte       = 8'h00;
      w_half       = 16'h0000;
      o_byte_mask  = 4'b1111;
      o_store_word = i_store_data;
      o_load_data  = i_mem_word;

      case (i_addr_lo)
         2'd0:    w_byte = i_mem_word[7:0];
         2'd1:    w_byte = i_mem_word[15:8];
         2'd2:    w_byte = i_mem_word[23:16];
         default: w_byte = i_mem_word[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

      // Store data is replicated across lanes; the mask selects the live one.
      case (i_size)
         SZ_BYTE: begin
            o_byte_mask  = 4'b0001 << i_addr_lo;
            o_store_word = {4{i_store_data[7:0]}};
            o_load_data  = {{24{i_is_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_byte_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_store_word = {2{i_store_data[15:0]}};
            o_load_data  = {{16{i_is_signed & w_half[15]}}, w_half};
         end
         default: begin
            o_byte_mask  = 4'b1111;
            o_store_word = i_store_data;
            o_load_data  = i_mem_word;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_memory_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_memory_controller                                                |
// | Multi-cycle data memory behind the EX/MEM stage with stall handshake. |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module data_memory_controller
   import data_memory_controller_pkg::*;
#(
   parameter int MEM_DEPTH_WORDS = 256,
   parameter int ACCESS_LATENCY  = 4
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  READ_WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        MISALIGNED
);

   localparam int c_idx_w = $clog2(MEM_DEPTH_WORDS);
   localparam int c_cnt_w = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(ACCESS_LATENCY - 1);

   mem_state_e          r_state;
   mem_state_e          w_state_next;
   logic [c_cnt_w-1:0]  r_count;
   op_decode_t          r_op;
   logic [c_idx_w+1:0]  r_addr;
   logic [31:0]         r_wdata;
   logic                r_misaligned;
   logic [31:0]         r_read_data;
   logic [31:0]         r_mem [MEM_DEPTH_WORDS];

   op_decode_t          w_in_op;
   logic                w_in_misaligned;
   logic                w_access;
   logic [31:0]         w_mem_word;
   logic [3:0]          w_byte_mask;
   logic [31:0]         w_mask_bits;
   logic [31:0]         w_store_word;
   logic [31:0]         w_load_data;
   logic [31:0]         w_merged;
   logic                w_unused_addr;

   assign w_in_op         = decode_op(READ_WRITE);
   assign w_in_misaligned = is_misaligned(w_in_op.size, ADDRESS[1:0]);
   assign w_unused_addr   = ^ADDRESS[31:c_idx_w+2];

   assign w_access    = (r_state == ST_BUSY) && (r_count == '0) && r_op.valid;
   assign w_mem_word  = r_mem[r_addr[c_idx_w+1:2]];
   assign w_mask_bits = {{8{w_byte_mask[3]}}, {8{w_byte_mask[2]}},
                         {8{w_byte_mask[1]}}, {8{w_byte_mask[0]}}};
   assign w_merged    = (w_mem_word & ~w_mask_bits) | (w_store_word & w_mask_bits);
   assign READ_DATA   = r_read_data;

   data_mem_lane_align u_lane_align (
      .i_size_byte_unused_guard (1'b0),
      .i_size                   (r_op.size),
      .i_is_signed              (r_op.is_signed),
      .i_addr_lo                (r_addr[1:0]),
      .i_store_data             (r_wdata),
      .i_mem_word               (w_mem_word),
      .o_byte_mask              (w_byte_mask),
      .o_store_word             (w_store_word),
      .o_load_data              (w_load_data)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // BUSYWAIT is forced low while reset is asserted even if an op is presented.
   always_comb begin
      w_state_next = r_state;
      BUSYWAIT     = 1'b0;
      MISALIGNED   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            BUSYWAIT = RESET & w_in_op.valid;
            if (w_in_op.valid) begin
               w_state_next = w_in_misaligned ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            BUSYWAIT = RESET;
            if (r_count == '0) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            MISALIGNED   = r_misaligned;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_count      <= '0;
         r_op         <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_misaligned <= 1'b0;
         r_read_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_in_op.valid) begin
                  r_op         <= w_in_op;
                  r_addr       <= ADDRESS[c_idx_w+1:0];
                  r_wdata      <= WRITE_DATA;
                  r_misaligned <= w_in_misaligned;
                  if (!w_in_misaligned) begin
                     r_count <= c_cnt_load;
                  end
               end
            end
            ST_BUSY: begin
               if (r_count != '0) begin
                  r_count <= r_count - 1'b1;
               end else if (r_op.is_load) begin
                  r_read_data <= w_load_data;
               end
            end
            default: r_misaligned <= 1'b0;
         endcase
      end
   end

   // Array is never reset; an aborted access leaves it untouched because
   // reset drops the state out of BUSY before the access edge.
   always_ff @(posedge CLK) begin
      if (w_access && !r_op.is_load) begin
         r_mem[r_addr[c_idx_w+1:2]] <= w_merged;
      end
   end

endmodule
`default_nettype wire

// File: doc/data_memory_controller.md
DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 SHALL have parameter MEM_DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter ACCESS_LATENCY, default 4, number of BUSY cycles per legal access (>=1).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: CLK and RESET.
REQ-004 SHALL have the following ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ_WRITE  in  4  memory op from the EX/MEM register; encoding per REQ-006.
- ADDRESS  in  32  byte address (EX/MEM ALU result).
- WRITE_DATA  in  32  store data (EX/MEM DATA2).
- READ_DATA  out  32  load result, sign/zero-extended, registered.
- BUSYWAIT  out  1  stall request to all pipeline registers.
- MISALIGNED  out  1  misaligned-access flag, valid in the DONE cycle only.

Function
REQ-005 SHALL implement the memory side of the EX/MEM interface: it accepts the op, holds BUSYWAIT until done, and returns data.
REQ-006 SHALL decode READ_WRITE as follows:
- Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
- Stores: 0101 SB, 0110 SH, 0111 SW.
- Every other code, including 0000, is NONE.
REQ-007 SHALL use a three-state FSM with states IDLE, BUSY and DONE.
REQ-008 In IDLE with a legal aligned op, SHALL:
- latch op, ADDRESS and WRITE_DATA;
- load the counter with ACCESS_LATENCY-1;
- go to BUSY.
REQ-009 In IDLE with a misaligned op, SHALL go to DONE with MISALIGNED pending; no array access and no BUSY cycles.
- Misaligned means: half access with ADDRESS[0]=1, or word access with ADDRESS[1:0]!=0.
REQ-010 In IDLE with NONE, SHALL stay in IDLE with BUSYWAIT=0.
REQ-011 In BUSY, SHALL decrement the counter each cycle. At counter 0 it SHALL perform the access on that edge and go to DONE.
REQ-012 In DONE, SHALL hold BUSYWAIT=0 for exactly one cycle and return to IDLE without re-sampling the inputs in that cycle.
REQ-013 BUSYWAIT SHALL be combinational: (state==IDLE and op!=NONE) or state==BUSY.
REQ-014 A legal access SHALL hold BUSYWAIT high for ACCESS_LATENCY+1 consecutive cycles; a misaligned access holds it high for 1 cycle.
REQ-015 The word index SHALL be ADDRESS[log2(MEM_DEPTH_WORDS)+1:2]; upper address bits are ignored (wrap-around).
REQ-016 SB SHALL write WRITE_DATA[7:0] to byte lane ADDRESS[1:0]; SH SHALL write WRITE_DATA[15:0] to half ADDRESS[1]; SW SHALL write the full word. Other lanes are unchanged.
REQ-017 A load SHALL update READ_DATA on the BUSY->DONE edge:
- LB and LH sign-extend; LBU and LHU zero-extend; LW is unmodified.
- READ_DATA holds its value until the next completed load.
REQ-018 A store or a misaligned op SHALL leave READ_DATA unchanged. A misaligned op SHALL also leave memory unchanged.
REQ-019 MISALIGNED SHALL be 1 only in the DONE cycle of a misaligned op, and 0 otherwise.
REQ-020 Changes on the input ports during BUSY SHALL be ignored; only the values latched in IDLE are used.

Reset
REQ-021 While RESET=0, the block SHALL immediately force state=IDLE, counter=0, READ_DATA=0, BUSYWAIT=0 and MISALIGNED=0.
REQ-022 Reset during BUSY SHALL abort the pending access with no array write.
REQ-023 The memory array SHALL NOT be cleared by reset.
REQ-024 The first op SHALL be sampled on the first rising edge after RESET returns to 1.

Structure
REQ-025 The op encodings (REQ-006) and the FSM state type SHALL be defined in a shared package used by the pipeline and this block.
REQ-026 Byte-lane write-mask generation and load extension SHALL be in a combinational sub-module, data_mem_lane_align.
REQ-027 The RTL SHALL be 120-400 lines including the sub-module.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> BUSYWAIT high 5 cycles each, then READ_DATA=0xDEADBEEF in the DONE cycle.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- LH @0x11 -> BUSYWAIT high 1 cycle, MISALIGNED=1 in DONE, READ_DATA unchanged, memory unchanged.
- SW 0x12345678 @0x400 (wraps to word 0), then LW @0x0 -> 0x12345678.
- RESET=0 in the 2nd BUSY cycle of SW 0xAAAAAAAA @0x20 -> BUSYWAIT=0 at once; after release, LW @0x20 returns the prior contents.
- Op changes from SW to NONE during BUSY -> the store still completes using the latched data, and DONE lasts exactly 1 cycle.
